// File: rtl/noc_input_buffer_if.sv
// noc_input_buffer_if: link, routing-handshake and crossbar signals of one router input port
// The optional overflow flag exists only when NOC_INPUT_BUFFER_OVERFLOW_EN is defined.
interface noc_input_buffer_if #(
    parameter int FLIT_W = 16
);
    logic              rx;
    logic [FLIT_W-1:0] data_in;
    logic              credit_o;
    logic              h;
    logic              ack_h;
    logic              data_av;
    logic [FLIT_W-1:0] data_out;
    logic              data_ack;
    logic              sender;
`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
    logic              overflow;

    modport master (
        input  rx, data_in, ack_h, data_ack,
        output credit_o, h, data_av, data_out, sender, overflow
    );

    modport slave (
        output rx, data_in, ack_h, data_ack,
        input  credit_o, h, data_av, data_out, sender, overflow
    );
`else
    modport master (
        input  rx, data_in, ack_h, data_ack,
        output credit_o, h, data_av, data_out, sender
    );

    modport slave (
        output rx, data_in, ack_h, data_ack,
        input  credit_o, h, data_av, data_out, sender
    );
`endif
endinterface

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: credit-controlled flit FIFO that requests a route per packet and forwards it
// Optional sticky overflow flag enabled by defining NOC_INPUT_BUFFER_OVERFLOW_EN.
module noc_input_buffer #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input logic clock,
    input logic reset,
    noc_input_buffer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD
    } state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    state_t            state_q, state_d;
    logic              h_q, h_d;
    logic              sender_q, sender_d;
    logic [FLIT_W-1:0] rem_q, rem_d;
    logic              push;
    logic              pop;
    logic              in_pkt;

    assign bus.credit_o = count_q != FULL;
    assign push         = bus.rx && bus.credit_o;
    assign in_pkt       = state_q == S_HEADER || state_q == S_SIZE || state_q == S_PAYLOAD;
    assign bus.data_av  = in_pkt && count_q != '0;
    assign pop          = bus.data_av && bus.data_ack;
    assign bus.data_out = mem_q[rd_ptr_q];
    assign bus.h        = h_q;
    assign bus.sender   = sender_q;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // Flit storage; contents need no reset because count gates every read
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_in;
    end

    // Packet sequencer: request the route for the head packet, then count it out
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        sender_d = sender_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    h_d     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.ack_h) begin
                    h_d      = 1'b0;
                    sender_d = 1'b1;
                    state_d  = S_HEADER;
                end
            end
            S_HEADER: begin
                if (pop) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (pop) begin
                    rem_d    = bus.data_out;
                    sender_d = bus.data_out != '0;
                    state_d  = bus.data_out == '0 ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    rem_d = rem_q - FLIT_W'(1);
                    if (rem_q == FLIT_W'(1)) begin
                        sender_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer, occupancy and sequencer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            h_q      <= 1'b0;
            sender_q <= 1'b0;
            rem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            h_q      <= h_d;
            sender_q <= sender_d;
            rem_q    <= rem_d;
        end
    end

`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
    logic overflow_q;

    assign bus.overflow = overflow_q;

    // Sticky record of any flit the neighbour sent while no credit was available
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_q || (bus.rx && !bus.credit_o);
    end
`endif
endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer: directed checks of buffering, routing handshake and packet forwarding
module tb_noc_input_buffer;
    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    noc_input_buffer_if #(.FLIT_W(16)) bus ();

    noc_input_buffer #(.FLIT_W(16), .DEPTH(8), .PTR_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        bus.rx      = 1'b1;
        bus.data_in = v;
        cyc();
        bus.rx      = 1'b0;
    endtask

    initial begin
        logic [15:0] full_exp [7];
        reset        = 1'b0;
        bus.rx       = 1'b0;
        bus.data_in  = '0;
        bus.ack_h    = 1'b0;
        bus.data_ack = 1'b0;
        cyc();
        cyc();
        chk("rst_h", 32'(bus.h), 0);
        chk("rst_sender", 32'(bus.sender), 0);
        chk("rst_data_av", 32'(bus.data_av), 0);
        chk("rst_credit", 32'(bus.credit_o), 1);
        reset = 1'b1;
        cyc();
        cyc();
        chk("idle_h", 32'(bus.h), 0);
        chk("idle_data_av", 32'(bus.data_av), 0);
        chk("idle_credit", 32'(bus.credit_o), 1);
`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
        chk("rst_overflow", 32'(bus.overflow), 0);
`endif

        // normal packet, size 2
        push(16'h1200);
        push(16'h0002);
        push(16'h00A1);
        push(16'h00A2);
        chk("pk1_h_up", 32'(bus.h), 1);
        cyc();
        chk("pk1_hold_h", 32'(bus.h), 1);
        chk("pk1_hold_av", 32'(bus.data_av), 0);
        chk("pk1_hold_sender", 32'(bus.sender), 0);
        bus.ack_h    = 1'b1;
        bus.data_ack = 1'b1;
        #1;
        chk("pk1_no_av_in_req", 32'(bus.data_av), 0);
        cyc();
        bus.ack_h = 1'b0;
        chk("pk1_h_fall", 32'(bus.h), 0);
        chk("pk1_sender", 32'(bus.sender), 1);
        chk("pk1_av", 32'(bus.data_av), 1);
        chk("pk1_f0", 32'(bus.data_out), 32'h1200);
        cyc();
        chk("pk1_f1", 32'(bus.data_out), 32'h0002);
        cyc();
        chk("pk1_f2", 32'(bus.data_out), 32'h00A1);
        cyc();
        chk("pk1_f3", 32'(bus.data_out), 32'h00A2);
        chk("pk1_sender_last", 32'(bus.sender), 1);
        cyc();
        chk("pk1_sender_end", 32'(bus.sender), 0);
        chk("pk1_av_end", 32'(bus.data_av), 0);
        chk("pk1_credit_end", 32'(bus.credit_o), 1);
        cyc();
        chk("pk1_no_h", 32'(bus.h), 0);
        bus.data_ack = 1'b0;

        // zero-size packet
        push(16'h3400);
        push(16'h0000);
        chk("pk0_h", 32'(bus.h), 1);
        bus.ack_h    = 1'b1;
        bus.data_ack = 1'b1;
        cyc();
        bus.ack_h = 1'b0;
        chk("pk0_f0", 32'(bus.data_out), 32'h3400);
        chk("pk0_sender", 32'(bus.sender), 1);
        cyc();
        chk("pk0_f1", 32'(bus.data_out), 32'h0000);
        chk("pk0_av1", 32'(bus.data_av), 1);
        cyc();
        chk("pk0_sender_end", 32'(bus.sender), 0);
        chk("pk0_av_end", 32'(bus.data_av), 0);
        cyc();
        chk("pk0_no_h", 32'(bus.h), 0);
        chk("pk0_still_idle_av", 32'(bus.data_av), 0);
        bus.data_ack = 1'b0;

        // full buffer with grant withheld: header, size 6, payload B0..B5
        full_exp[0] = 16'h0006;
        for (int i = 0; i < 6; i++) full_exp[i+1] = 16'h00B0 + 16'(i);
        push(16'h5600);
        for (int i = 0; i < 6; i++) push(full_exp[i]);
        chk("full_credit7", 32'(bus.credit_o), 1);
        push(full_exp[6]);
        chk("full_credit8", 32'(bus.credit_o), 0);
`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
        chk("full_overflow_pre", 32'(bus.overflow), 0);
`endif
        push(16'hDEAD);
        chk("full_drop_credit", 32'(bus.credit_o), 0);
`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
        chk("full_overflow", 32'(bus.overflow), 1);
`endif
        bus.ack_h = 1'b1;
        cyc();
        bus.ack_h = 1'b0;
        chk("full_credit_granted", 32'(bus.credit_o), 0);
        chk("full_f0", 32'(bus.data_out), 32'h5600);
        bus.data_ack = 1'b1;
        cyc();
        chk("full_credit_back", 32'(bus.credit_o), 1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("full_f%0d", i + 1), 32'(bus.data_out), 32'(full_exp[i]));
            cyc();
        end
        chk("full_sender_end", 32'(bus.sender), 0);
        chk("full_av_end", 32'(bus.data_av), 0);
`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
        chk("full_overflow_sticky", 32'(bus.overflow), 1);
`endif
        bus.data_ack = 1'b0;

        // back-to-back packets of size 1
        push(16'h7000);
        push(16'h0001);
        push(16'h00C1);
        push(16'h7100);
        push(16'h0001);
        push(16'h00C2);
        chk("b2b_h1", 32'(bus.h), 1);
        bus.ack_h    = 1'b1;
        bus.data_ack = 1'b1;
        cyc();
        bus.ack_h = 1'b0;
        chk("b2b_a0", 32'(bus.data_out), 32'h7000);
        cyc();
        chk("b2b_a1", 32'(bus.data_out), 32'h0001);
        cyc();
        chk("b2b_a2", 32'(bus.data_out), 32'h00C1);
        cyc();
        chk("b2b_sender_fall", 32'(bus.sender), 0);
        chk("b2b_h_gap", 32'(bus.h), 0);
        cyc();
        chk("b2b_h2", 32'(bus.h), 1);
        chk("b2b_h2_av", 32'(bus.data_av), 0);
        bus.ack_h = 1'b1;
        cyc();
        bus.ack_h = 1'b0;
        chk("b2b_b0", 32'(bus.data_out), 32'h7100);
        chk("b2b_sender2", 32'(bus.sender), 1);
        cyc();
        chk("b2b_b1", 32'(bus.data_out), 32'h0001);
        cyc();
        chk("b2b_b2", 32'(bus.data_out), 32'h00C2);
        cyc();
        chk("b2b_sender_end", 32'(bus.sender), 0);
        chk("b2b_av_end", 32'(bus.data_av), 0);
        bus.data_ack = 1'b0;

        // reset in the middle of a payload
        push(16'h7200);
        push(16'h0005);
        push(16'h00D1);
        push(16'h00D2);
        push(16'h00D3);
        bus.ack_h = 1'b1;
        cyc();
        bus.ack_h    = 1'b0;
        bus.data_ack = 1'b1;
        cyc();
        cyc();
        bus.data_ack = 1'b0;
        chk("mid_payload_head", 32'(bus.data_out), 32'h00D1);
        chk("mid_payload_sender", 32'(bus.sender), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_h", 32'(bus.h), 0);
        chk("mid_rst_sender", 32'(bus.sender), 0);
        chk("mid_rst_av", 32'(bus.data_av), 0);
        chk("mid_rst_credit", 32'(bus.credit_o), 1);
`ifdef NOC_INPUT_BUFFER_OVERFLOW_EN
        chk("mid_rst_overflow", 32'(bus.overflow), 0);
`endif
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_h", 32'(bus.h), 0);
        chk("post_rst_av", 32'(bus.data_av), 0);
        push(16'h7300);
        push(16'h0000);
        chk("post_rst_h_up", 32'(bus.h), 1);
        bus.ack_h    = 1'b1;
        bus.data_ack = 1'b1;
        cyc();
        bus.ack_h = 1'b0;
        chk("post_rst_f0", 32'(bus.data_out), 32'h7300);
        cyc();
        chk("post_rst_f1", 32'(bus.data_out), 32'h0000);
        cyc();
        chk("post_rst_sender_end", 32'(bus.sender), 0);
        chk("post_rst_av_end", 32'(bus.data_av), 0);
        bus.data_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/noc_input_buffer.md
Name: noc_input_buffer

Overview:
- Per-port input buffer for the NoC router; the requesting side of the switch controller's h/ack_h routing handshake.
- Receives flits from a neighbour link under credit flow control and stores them in a FIFO.
- Raises a routing request for each packet header, then forwards the whole packet to the crossbar.
- Holds sender high for the packet's duration; its falling edge tells the switch controller to release the output port.

Parameters:
- FLIT_W, 16, flit width in bits. Header: target X in [15:12], target Y in [11:8].
- DEPTH, 8, FIFO depth in flits. Power of two, at least 4.
- PTR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clock  in  1  single clock; all flops rise-edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  neighbour presents a flit on data_in.
- data_in  in  FLIT_W  incoming flit.
- credit_o  out  1  buffer can accept a flit (count < DEPTH).
- h  out  1  routing request for the header at the FIFO head.
- ack_h  in  1  switch controller grants the request.
- data_av  out  1  flit valid on data_out toward the crossbar.
- data_out  out  FLIT_W  FIFO head flit, combinational from storage.
- data_ack  in  1  crossbar consumes data_out.
- sender  out  1  high from grant until the packet's last flit is consumed.

Behaviour:
- Reset (reset=0, async): h=0, sender=0, data_av=0, credit_o=1, pointers and count=0, FSM=S_IDLE, remaining=0. FIFO contents are don't-care.
- Push: on rx=1 and credit_o=1, write data_in at wr_ptr; wr_ptr+1 mod DEPTH; count+1.
- Push while full: rx=1 with credit_o=0 is ignored; no state change.
- credit_o is combinational: count<DEPTH. No push is accepted while full, even if a pop happens the same cycle.
- Pop: on data_av=1 and data_ack=1, rd_ptr+1 mod DEPTH; count-1. Push and pop in the same cycle leave count unchanged.
- A flit written at edge t appears on data_out after edge t.
- data_av = (FSM in S_HEADER, S_SIZE or S_PAYLOAD) and count>0. It is 0 when the FIFO is empty.
- Packet format: flit0 header, flit1 size N (payload flit count, full FLIT_W unsigned), then N payload flits.
- S_IDLE: if count>0, set h<=1 and go to S_REQ.
- S_REQ: h stays 1; data_av=0; the header is held at the head and not popped. On ack_h=1: h<=0, sender<=1, go to S_HEADER. h falls the cycle after the grant.
- S_HEADER: header popped → S_SIZE.
- S_SIZE: on pop, remaining<=data_out.
  - If data_out==0: sender<=0, go to S_IDLE.
  - Else go to S_PAYLOAD.
- S_PAYLOAD: each pop decrements remaining. A pop with remaining==1 sets sender<=0 and goes to S_IDLE.
- sender falls exactly one edge after the last flit's pop cycle.
- ack_h is ignored in every state except S_REQ.
- data_ack is ignored when data_av=0.
- Back-to-back packets: after returning to S_IDLE, a next header already buffered raises h on the following edge. There is at least one idle cycle between sender falling and h rising.
- Stalls: the FSM holds its state indefinitely while the FIFO is empty mid-packet or data_ack=0. sender stays 1 throughout.
- Pointer wrap-around is transparent; full is count==DEPTH and empty is count==0.

Optional Feature:
- Macro NOC_INPUT_BUFFER_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), reset 0. It is set on the edge where rx=1 and credit_o=0. It is sticky and clears only on reset.
- Not defined: the port is absent; push-while-full is silently dropped.

Test Plan:
- Reset: hold reset=0, then release → h=0, sender=0, data_av=0, credit_o=1. No output change until rx.
- Normal packet: push 16'h1200, 16'h0002, 16'h00A1, 16'h00A2. Pulse ack_h 3 cycles after h rises; hold data_ack=1.
  - Expect h high only until the cycle after ack_h, then sender=1.
  - data_out sequence is 1200, 0002, 00A1, 00A2.
  - sender=0 one edge after the 00A2 pop; FIFO empty.
- Zero-size packet: push 16'h3400, 16'h0000, ack_h → exactly 2 flits popped, sender back to 0, FSM in S_IDLE, no third pop.
- Full buffer (DEPTH=8), ack_h withheld: push 8 flits → credit_o=0 after the 8th. A 9th rx=1 is dropped (count stays 8; overflow=1 with the macro). Grant and pop one flit → credit_o=1 on the next cycle.
- Back-to-back packets: two packets of size 1 buffered together → h asserts twice, with sender falling before the second h. Both packets are delivered intact in order.
- Reset mid-packet: assert reset while in S_PAYLOAD with 3 flits buffered → all outputs take reset values immediately; count=0 after release. A newly pushed header raises h normally.
